full_adder_core: RTL and testbench
==================================

Name: full_adder_core

Overview:
WIDTH-bit ripple-carry adder built from 1-bit full-adder cells (sum = a^b^cin, carry = majority(a,b,cin)).
- Provides a zero-latency combinational result and a one-cycle registered result with a valid flag.
- Serves as the arithmetic leaf for datapaths that need both a raw and a pipelined sum.
- WIDTH=1 gives the classic single-bit full adder.

Parameters:
WIDTH, 1, operand width in bits (legal range 1..64)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A (unsigned, or two's complement for the ovf output)
b  input  WIDTH  operand B
cin  input  1  carry into bit 0
in_valid  input  1  qualifies a, b, cin for capture into the output register
sum_comb  output  WIDTH  combinational sum of a+b+cin
cout_comb  output  1  combinational carry out of the MSB
sum  output  WIDTH  registered sum
cout  output  1  registered carry out
ovf  output  1  registered signed overflow
out_valid  output  1  registered result valid

Behaviour:
- Reset: clk is the single clock and rst_n is asynchronous and active-low. While rst_n=0, sum=0, cout=0, ovf=0 and out_valid=0, independent of clk. Release is synchronised by the usual two-flop reset release outside this block. No internal synchroniser.
- Cell equations, bit i, with c0=cin:
  - s[i] = a[i]^b[i]^c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - cout = c[WIDTH].
  - Result equals (a+b+cin) mod 2^WIDTH, and cout is bit WIDTH of the full (WIDTH+1)-bit sum.
- Combinational path:
  - sum_comb/cout_comb follow a, b and cin with zero latency, independent of clk, rst_n and in_valid.
  - Outputs are X-free whenever the inputs are known.
- Signed overflow: ovf_next = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1, c[0] is cin, so ovf_next = cout ^ cin.
- Registered path, latency 1:
  - At a rising clk edge with in_valid=1: sum, cout and ovf load the combinational result, and out_valid goes to 1.
  - At a rising clk edge with in_valid=0: sum, cout and ovf hold their previous values, and out_valid goes to 0.
  - Back-to-back in_valid gives one result per cycle. There is no backpressure and no handshake beyond the valid flag.
- Reset mid-operation: asserting rst_n clears all registered outputs immediately, including a result captured in the same cycle. The combinational outputs are unaffected.
- Boundaries:
  - All-ones + all-ones + cin=1 gives sum = all-ones and cout=1.
  - 0+0+0 gives all-zero with cout=0.
  - Wrap-around is modulo 2^WIDTH, with no saturation.
- Implementation:
  - A separate 1-bit cell is instantiated WIDTH times via generate.
  - No behavioural "+" operator in the ripple chain, so the cell structure is explicit for verification.

Test Plan:
- WIDTH=1, exhaustive truth table: apply (a,b,cin) = 000,001,010,011,100,101,110,111, spaced 5 time units apart.
  - Required sum_comb/cout_comb = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
  - With in_valid=1, the same values must appear on sum/cout one clock later with out_valid=1.
- WIDTH=8 boundary: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0.
- WIDTH=8 signed overflow:
  - a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
  - a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, ovf=1.
- Valid gating: capture a result with in_valid=1, then drop in_valid and change the operands for 3 cycles.
  - sum/cout/ovf must hold the captured value.
  - out_valid must be 0 from the first edge after in_valid falls.
  - sum_comb must track the new operands.
- Async reset: with out_valid=1 and sum nonzero, pulse rst_n low between clock edges.
  - sum, cout, ovf and out_valid must go to 0 immediately, without a clock edge.
  - After rst_n returns high, the first edge with in_valid=1 produces a correct result.
- Random: 1000 random a/b/cin vectors with random in_valid, WIDTH=1 and WIDTH=16, checked against a reference model of (a+b+cin).

Source files
------------

// File: rtl/full_adder_core.sv
// Ripple-carry adder from explicit 1-bit full-adder cells: combinational sum plus registered sum/cout/ovf.
// Latency: 0 cycles on sum_comb/cout_comb, 1 cycle on sum/cout/ovf/out_valid.
// Backpressure: none; in_valid qualifies capture and out_valid follows it one cycle later.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module full_adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_comb,
    output logic             cout_comb,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;
    logic             ovf_next;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    assign sum_comb  = sum_bits;
    assign cout_comb = carry[WIDTH];

    // Two's-complement overflow: carry into and out of the sign bit disagree
    assign ovf_next  = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_bits;
                cout <= carry[WIDTH];
                ovf  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_core.sv
// Directed and reference-model checks of full_adder_core at WIDTH 1, 8 and 16.
// All three instances share clock, reset, cin and in_valid; operands are per instance.

module tb_full_adder_core;

    logic clk = 1'b0;
    logic rst_n;
    logic cin;
    logic in_valid;

    logic        a1, b1;
    logic        sc1, cc1, s1, co1, ov1, ovl1;
    logic [7:0]  a8, b8;
    logic [7:0]  sc8, s8;
    logic        cc8, co8, ov8, ovl8;
    logic [15:0] a16, b16;
    logic [15:0] sc16, s16;
    logic        cc16, co16, ov16, ovl16;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    full_adder_core #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin), .in_valid(in_valid),
        .sum_comb(sc1), .cout_comb(cc1), .sum(s1), .cout(co1), .ovf(ov1), .out_valid(ovl1)
    );

    full_adder_core #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin), .in_valid(in_valid),
        .sum_comb(sc8), .cout_comb(cc8), .sum(s8), .cout(co8), .ovf(ov8), .out_valid(ovl8)
    );

    full_adder_core #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin), .in_valid(in_valid),
        .sum_comb(sc16), .cout_comb(cc16), .sum(s16), .cout(co16), .ovf(ov16), .out_valid(ovl16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive an 8-bit vector, check the comb path, then the registered path one edge later
    task automatic run8(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic ec, input logic eo);
        a8 = va; b8 = vb; cin = vc; in_valid = 1'b1;
        #1;
        chk({tag, " sum_comb"},  64'(sc8), 64'(es));
        chk({tag, " cout_comb"}, 64'(cc8), 64'(ec));
        @(posedge clk); #1;
        chk({tag, " sum"},       64'(s8),   64'(es));
        chk({tag, " cout"},      64'(co8),  64'(ec));
        chk({tag, " ovf"},       64'(ov8),  64'(eo));
        chk({tag, " out_valid"}, 64'(ovl8), 64'(1));
    endtask

    function automatic logic ovf_model(input int sa, input int sb, input int c, input int w);
        int r, hi, lo;
        r  = sa + sb + c;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (r > hi) || (r < lo);
    endfunction

    // Truth table of the 1-bit cell, indexed by {a,b,cin}
    logic [7:0] tt_s   = 8'b1001_0110;
    logic [7:0] tt_c   = 8'b1110_1000;
    logic [7:0] tt_ovf = 8'b0100_0010;

    // Operands applied while in_valid is low: a, b, cin, expected sum_comb
    logic [7:0] hold_a [3] = '{8'h10, 8'hF0, 8'h01};
    logic [7:0] hold_b [3] = '{8'h20, 8'h20, 8'h02};
    logic       hold_c [3] = '{1'b0,  1'b1,  1'b0};
    logic [7:0] hold_s [3] = '{8'h30, 8'h11, 8'h03};

    initial begin
        logic [2:0]  v;
        logic [16:0] full16;
        logic [1:0]  full1;
        logic [15:0] e_s16;
        logic        e_c16, e_o16, e_s1, e_c1, e_o1, e_v;

        rst_n = 1'b0; cin = 1'b0; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        #3;
        chk("reset sum",       64'(s8),   64'(0));
        chk("reset cout",      64'(co8),  64'(0));
        chk("reset ovf",       64'(ov8),  64'(0));
        chk("reset out_valid", 64'(ovl8), 64'(0));
        chk("reset out_valid w1",  64'(ovl1),  64'(0));
        chk("reset out_valid w16", 64'(ovl16), 64'(0));
        @(posedge clk); #1;
        chk("held reset sum", 64'(s16), 64'(0));
        rst_n = 1'b1;

        // Combinational truth table, 5 time units apart, clock-independent
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin = v[0];
            #5;
            chk($sformatf("tt comb sum %0d", i),  64'(sc1), 64'(tt_s[v]));
            chk($sformatf("tt comb cout %0d", i), 64'(cc1), 64'(tt_c[v]));
        end

        // Same table through the register
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin = v[0]; in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("tt reg sum %0d", i),   64'(s1),   64'(tt_s[v]));
            chk($sformatf("tt reg cout %0d", i),  64'(co1),  64'(tt_c[v]));
            chk($sformatf("tt reg ovf %0d", i),   64'(ov1),  64'(tt_ovf[v]));
            chk($sformatf("tt reg valid %0d", i), 64'(ovl1), 64'(1));
        end

        run8("ff+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run8("0+0+0",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run8("7f+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("80+80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8("12+34",   8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Valid gating: the 8'h46 result must hold while operands move
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = hold_a[i]; b8 = hold_b[i]; cin = hold_c[i];
            #1;
            chk($sformatf("gate sum_comb %0d", i), 64'(sc8), 64'(hold_s[i]));
            @(posedge clk); #1;
            chk($sformatf("gate sum %0d", i),       64'(s8),   64'(8'h46));
            chk($sformatf("gate cout %0d", i),      64'(co8),  64'(0));
            chk($sformatf("gate ovf %0d", i),       64'(ov8),  64'(0));
            chk($sformatf("gate out_valid %0d", i), 64'(ovl8), 64'(0));
        end

        // Async reset between edges clears registers without a clock
        run8("pre-rst 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst sum",       64'(s8),   64'(0));
        chk("arst cout",      64'(co8),  64'(0));
        chk("arst ovf",       64'(ov8),  64'(0));
        chk("arst out_valid", 64'(ovl8), 64'(0));
        chk("arst sum_comb",  64'(sc8),  64'(8'h80));
        rst_n = 1'b1;
        run8("post-rst 55+22+1", 8'h55, 8'h22, 1'b1, 8'h78, 1'b0, 1'b0);

        // Random vectors against a reference model for WIDTH 1 and 16
        e_s16 = 16'h0; e_c16 = 1'b0; e_o16 = 1'b0;
        e_s1  = 1'b0;  e_c1  = 1'b0; e_o1  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        e_v = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom);
            cin = 1'($urandom); in_valid = 1'($urandom);
            full16 = {1'b0, a16} + {1'b0, b16} + {16'b0, cin};
            full1  = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
            #1;
            chk("rnd w16 sum_comb",  64'(sc16), 64'(full16[15:0]));
            chk("rnd w16 cout_comb", 64'(cc16), 64'(full16[16]));
            chk("rnd w1 sum_comb",   64'(sc1),  64'(full1[0]));
            chk("rnd w1 cout_comb",  64'(cc1),  64'(full1[1]));
            if (in_valid) begin
                e_s16 = full16[15:0]; e_c16 = full16[16];
                e_o16 = ovf_model(int'($signed(a16)), int'($signed(b16)), int'(cin), 16);
                e_s1  = full1[0]; e_c1 = full1[1];
                e_o1  = ovf_model(a1 ? -1 : 0, b1 ? -1 : 0, int'(cin), 1);
            end
            e_v = in_valid;
            @(posedge clk); #1;
            chk("rnd w16 sum",   64'(s16),   64'(e_s16));
            chk("rnd w16 cout",  64'(co16),  64'(e_c16));
            chk("rnd w16 ovf",   64'(ov16),  64'(e_o16));
            chk("rnd w16 valid", 64'(ovl16), 64'(e_v));
            chk("rnd w1 sum",    64'(s1),    64'(e_s1));
            chk("rnd w1 cout",   64'(co1),   64'(e_c1));
            chk("rnd w1 ovf",    64'(ov1),   64'(e_o1));
            chk("rnd w1 valid",  64'(ovl1),  64'(e_v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
